// File: rtl/bin_to_text_n.sv
//------------------------------------------------------------------------------
// bin_to_text_n : unsigned binary to fixed-width ASCII decimal text converter
//   (serial double-dabble, one bit per cycle, valid/ready handshake both sides)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bin_to_text_n #(
  parameter int BIN_W    = 10,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*DIGITS-1:0]   text_output,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FORMAT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [8*DIGITS-1:0] text_q, text_d;
  logic                overflow_q, overflow_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_shift;
  logic [8*DIGITS-1:0] text_fmt;
  logic                seen_nz;
  logic [3:0]          digit;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  end

  // Scan from the top digit; zeros stay blank until the first nonzero digit.
  always_comb begin
    text_fmt = '0;
    seen_nz  = 1'b0;
    digit    = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit = bcd_q[4*i +: 4];
      if (ovf_q) begin
        text_fmt[8*i +: 8] = 8'h2D;
      end else if ((BLANK_LZ != 0) && !seen_nz && (digit == 4'd0) && (i != 0)) begin
        text_fmt[8*i +: 8] = 8'h20;
      end else begin
        text_fmt[8*i +: 8] = {4'h3, digit};
      end
      if (digit != 4'd0) begin
        seen_nz = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    text_d     = text_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = bin_data;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_shift;
        ovf_d = ovf_q | bcd_adj[BCD_W-1];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        text_d     = text_fmt;
        overflow_d = ovf_q;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      text_q     <= {DIGITS{8'h20}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      text_q     <= text_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = (state_q == DONE);
  assign text_output = text_q;
  assign overflow    = overflow_q;

endmodule

`default_nettype wire
